fetch_queue_unit: RTL and testbench



---
 rtl/fetch_queue_unit_pkg.sv | 21 ++
 rtl/fetch_queue_unit_fetch_fifo.sv | 75 +++++++
 rtl/fetch_queue_unit.sv | 114 +++++++++++
 tb/tb_fetch_queue_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch-front-end constants and types: instruction width, default reset PC,
// the NOP issued to decode when the queue is empty, and the queued entry layout.
package fetch_queue_unit_pkg;

    localparam int unsigned FQ_INS_W    = 32;
    localparam int unsigned FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FQ_NOP_INS  = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_INS_W-1:0] pc;
        logic [FQ_INS_W-1:0] ins;
    } fq_entry_t;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_PUSH,
        RSP_DROP
    } fq_rsp_e;

endpackage

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// DEPTH-entry FIFO holding {pc, instruction} pairs for the fetch queue.
// Combinational head read; synchronous clear has priority over push and pop.
module fetch_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned WIDTH = 2 * FQ_INS_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full || pop_i) && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: credit-limited sequential PC requests, in-order
// responses queued with their PCs, flush/redirect discarding in-flight fetches.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC,
    parameter logic [31:0] NOP_INS  = FQ_NOP_INS
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] PC_REQ,
    output logic        PC_REQ_VALID,
    input  logic        INS_CACHE_READY,
    input  logic        CACHE_RESP_VALID,
    input  logic [31:0] CACHE_INS,
    input  logic        FLUSH,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL_ENABLE,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_ID,
    output logic        INS_VALID
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    logic [31:0]   pc_req_q,   pc_req_d;
    logic [31:0]   rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q,     drop_d;

    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic [CW1-1:0] used_credits;
    logic           req_acc;
    logic           pop;
    fq_rsp_e        rsp_kind;
    fq_entry_t      wr_entry;
    fq_entry_t      head_entry;

    assign used_credits = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign PC_REQ_VALID = !RST && (used_credits < CW1'(DEPTH));
    assign PC_REQ       = pc_req_q;
    assign req_acc      = PC_REQ_VALID && INS_CACHE_READY && !FLUSH;
    assign pop          = INS_VALID && STALL_ENABLE && !FLUSH;

    assign INS_VALID   = !fifo_empty;
    assign INSTRUCTION = fifo_empty ? NOP_INS : head_entry.ins;
    assign PC_ID       = fifo_empty ? '0 : head_entry.pc;

    assign wr_entry.pc  = rsp_pc_q;
    assign wr_entry.ins = CACHE_INS;

    // Responses with nothing outstanding are a protocol error and are ignored.
    always_comb begin
        rsp_kind = RSP_NONE;
        if (CACHE_RESP_VALID && (inflight_q != '0)) begin
            rsp_kind = (FLUSH || (drop_q != '0)) ? RSP_DROP : RSP_PUSH;
        end
    end

    always_comb begin
        pc_req_d   = pc_req_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        if (req_acc)              inflight_d = inflight_d + CW'(1);
        if (rsp_kind != RSP_NONE) inflight_d = inflight_d - CW'(1);

        if (FLUSH) begin
            // No request is accepted while flushing, so every fetch still
            // outstanding after this cycle predates the redirect.
            pc_req_d = REDIRECT_PC;
            rsp_pc_d = REDIRECT_PC;
            drop_d   = inflight_d;
        end else begin
            if (req_acc)              pc_req_d = pc_req_q + 32'd4;
            if (rsp_kind == RSP_PUSH) rsp_pc_d = rsp_pc_q + 32'd4;
            if (rsp_kind == RSP_DROP) drop_d   = drop_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_req_q   <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_req_q   <= pc_req_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * FQ_INS_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (FLUSH),
        .push_i  (rsp_kind == RSP_PUSH),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a default instance plus one with a
// RESET_PC near the top of the address space sharing the same stimulus.
module tb_fetch_queue_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, rsp_valid, flush, stall_en;
    logic [31:0] cache_ins, redirect_pc;

    logic [31:0] pc_req, ins, pc_id;
    logic        pc_req_valid, ins_valid;
    logic [31:0] w_pc_req, w_ins, w_pc_id;
    logic        w_pc_req_valid, w_ins_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue_unit u_dut (
        .CLK              (clk),
        .RST              (rst),
        .PC_REQ           (pc_req),
        .PC_REQ_VALID     (pc_req_valid),
        .INS_CACHE_READY  (ready),
        .CACHE_RESP_VALID (rsp_valid),
        .CACHE_INS        (cache_ins),
        .FLUSH            (flush),
        .REDIRECT_PC      (redirect_pc),
        .STALL_ENABLE     (stall_en),
        .INSTRUCTION      (ins),
        .PC_ID            (pc_id),
        .INS_VALID        (ins_valid)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK              (clk),
        .RST              (rst),
        .PC_REQ           (w_pc_req),
        .PC_REQ_VALID     (w_pc_req_valid),
        .INS_CACHE_READY  (ready),
        .CACHE_RESP_VALID (rsp_valid),
        .CACHE_INS        (cache_ins),
        .FLUSH            (flush),
        .REDIRECT_PC      (redirect_pc),
        .STALL_ENABLE     (stall_en),
        .INSTRUCTION      (w_ins),
        .PC_ID            (w_pc_id),
        .INS_VALID        (w_ins_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0; stall_en = 1'b1;
        cache_ins = '0; redirect_pc = '0;

        @(negedge clk);
        chk("rst_pc_req", pc_req, 32'h0);
        chk("rst_req_valid", {31'b0, pc_req_valid}, 32'h0);
        chk("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("rst_instruction", ins, NOP);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_wrap_pc_req", w_pc_req, 32'hFFFF_FFFC);

        rst = 1'b0;
        #1;
        chk("rel_pc_req", pc_req, 32'h0);
        chk("rel_req_valid", {31'b0, pc_req_valid}, 32'h1);

        // Sequential fetch with one-cycle response latency.
        cyc();
        chk("seq_pc_req_1", pc_req, 32'h4);
        chk("seq_empty_1", {31'b0, ins_valid}, 32'h0);
        chk("wrap_pc_req_1", w_pc_req, 32'h0);
        rsp_valid = 1'b1; cache_ins = 32'hA0;
        cyc();
        chk("seq_pc_req_2", pc_req, 32'h8);
        chk("seq_valid_2", {31'b0, ins_valid}, 32'h1);
        chk("seq_ins_a0", ins, 32'hA0);
        chk("seq_pc_a0", pc_id, 32'h0);
        chk("wrap_pc_a0", w_pc_id, 32'hFFFF_FFFC);
        chk("wrap_ins_a0", w_ins, 32'hA0);
        cache_ins = 32'hA1;
        cyc();
        chk("seq_pc_req_3", pc_req, 32'hC);
        chk("seq_ins_a1", ins, 32'hA1);
        chk("seq_pc_a1", pc_id, 32'h4);
        chk("wrap_pc_a1", w_pc_id, 32'h0);
        cache_ins = 32'hA2;
        cyc();
        chk("seq_pc_req_4", pc_req, 32'h10);
        chk("seq_ins_a2", ins, 32'hA2);
        chk("seq_pc_a2", pc_id, 32'h8);

        // Cache not ready for five cycles: request held at 0x10.
        ready = 1'b0; cache_ins = 32'hA3;
        cyc();
        chk("nrdy_pc_req_0", pc_req, 32'h10);
        chk("nrdy_valid_0", {31'b0, pc_req_valid}, 32'h1);
        chk("nrdy_ins_a3", ins, 32'hA3);
        chk("nrdy_pc_a3", pc_id, 32'hC);
        rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("nrdy_pc_req", pc_req, 32'h10);
            chk("nrdy_valid", {31'b0, pc_req_valid}, 32'h1);
        end
        chk("drained_valid", {31'b0, ins_valid}, 32'h0);
        chk("drained_nop", ins, NOP);
        chk("drained_pc_id", pc_id, 32'h0);

        // Decode stalled for ten cycles: queue fills and credits run out.
        ready = 1'b1; stall_en = 1'b0;
        cyc();
        chk("stall_pc_req_0", pc_req, 32'h14);
        rsp_valid = 1'b1; cache_ins = 32'hB0;
        cyc();
        chk("stall_pc_b0", pc_id, 32'h10);
        chk("stall_ins_b0", ins, 32'hB0);
        chk("stall_pc_req_1", pc_req, 32'h18);
        cache_ins = 32'hB1;
        cyc();
        chk("stall_pc_req_2", pc_req, 32'h1C);
        cache_ins = 32'hB2;
        cyc();
        chk("stall_pc_req_3", pc_req, 32'h20);
        chk("stall_credit_out_3", {31'b0, pc_req_valid}, 32'h0);
        cache_ins = 32'hB3;
        cyc();
        chk("stall_full_valid", {31'b0, pc_req_valid}, 32'h0);
        rsp_valid = 1'b0;
        repeat (5) cyc();
        chk("stall_hold_valid", {31'b0, pc_req_valid}, 32'h0);
        chk("stall_hold_pc_req", pc_req, 32'h20);
        chk("stall_hold_pc_id", pc_id, 32'h10);
        chk("stall_hold_ins", ins, 32'hB0);

        stall_en = 1'b1;
        cyc();
        chk("release_pc_b1", pc_id, 32'h14);
        chk("release_ins_b1", ins, 32'hB1);
        chk("release_valid", {31'b0, pc_req_valid}, 32'h1);
        cyc();
        chk("release_pc_b2", pc_id, 32'h18);
        chk("release_ins_b2", ins, 32'hB2);
        chk("release_pc_req", pc_req, 32'h24);

        // Flush with two fetches in flight and two entries queued.
        stall_en = 1'b0;
        cyc();
        chk("preflush_pc_req", pc_req, 32'h28);
        chk("preflush_valid", {31'b0, pc_req_valid}, 32'h0);
        flush = 1'b1; redirect_pc = 32'h200;
        cyc();
        chk("flush_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("flush_nop", ins, NOP);
        chk("flush_pc_id", pc_id, 32'h0);
        chk("flush_pc_req", pc_req, 32'h200);
        chk("flush_req_valid", {31'b0, pc_req_valid}, 32'h1);
        flush = 1'b0; stall_en = 1'b1; rsp_valid = 1'b1; cache_ins = 32'hD0;
        cyc();
        chk("drop1_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("drop1_pc_req", pc_req, 32'h204);
        cache_ins = 32'hD1;
        cyc();
        chk("drop2_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("drop2_pc_req", pc_req, 32'h208);
        cache_ins = 32'hE0;
        cyc();
        chk("redir_ins_valid", {31'b0, ins_valid}, 32'h1);
        chk("redir_pc_id", pc_id, 32'h200);
        chk("redir_ins", ins, 32'hE0);
        chk("redir_pc_req", pc_req, 32'h20C);

        // Flush coinciding with a response and a pop.
        flush = 1'b1; redirect_pc = 32'h300; cache_ins = 32'hE1;
        cyc();
        chk("flush2_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("flush2_pc_id", pc_id, 32'h0);
        chk("flush2_pc_req", pc_req, 32'h300);
        chk("flush2_req_valid", {31'b0, pc_req_valid}, 32'h1);
        flush = 1'b0; ready = 1'b0; cache_ins = 32'hE2;
        cyc();
        chk("flush2_drop_valid", {31'b0, ins_valid}, 32'h0);
        chk("flush2_hold_pc_req", pc_req, 32'h300);
        ready = 1'b1; rsp_valid = 1'b0;
        cyc();
        chk("flush2_acc_pc_req", pc_req, 32'h304);
        ready = 1'b0; rsp_valid = 1'b1; cache_ins = 32'hF0;
        cyc();
        chk("flush2_f0_valid", {31'b0, ins_valid}, 32'h1);
        chk("flush2_f0_pc_id", pc_id, 32'h300);
        chk("flush2_f0_ins", ins, 32'hF0);

        // Asynchronous reset in the middle of a burst.
        ready = 1'b1; rsp_valid = 1'b0; stall_en = 1'b0;
        cyc();
        chk("burst_pc_req", pc_req, 32'h308);
        chk("burst_pc_id", pc_id, 32'h300);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc_req", pc_req, 32'h0);
        chk("arst_req_valid", {31'b0, pc_req_valid}, 32'h0);
        chk("arst_ins_valid", {31'b0, ins_valid}, 32'h0);
        chk("arst_instruction", ins, NOP);
        chk("arst_pc_id", pc_id, 32'h0);
        chk("arst_wrap_pc_req", w_pc_req, 32'hFFFF_FFFC);
        chk("arst_wrap_valid", {31'b0, w_pc_req_valid}, 32'h0);
        cyc();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
